// File: rtl/timer_preset_entry_pkg.sv
// Shared kitchen-timer definitions: FSM state encoding, keypad codes and BCD limits.
package timer_preset_entry_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StEntry = 2'd1,
      StArmed = 2'd2,
      StRun   = 2'd3
   } state_e;

   localparam logic [3:0] KEY_START_DEFAULT  = 4'hA;
   localparam logic [3:0] KEY_CANCEL_DEFAULT = 4'hB;
   localparam logic [3:0] BCD_MAX_DIGIT      = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS_SEC   = 4'd5;

   function automatic logic is_digit_key(input logic [3:0] code);
      return code <= BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/timer_preset_entry_if.sv
// Keypad-side inputs and counter-chain-side outputs of the preset entry block.
interface timer_preset_entry_if #(
   parameter int unsigned NUM_DIGITS = 3
);
   logic                    key_valid;
   logic [3:0]              key_code;
   logic                    busy;
   logic [4*NUM_DIGITS-1:0] preset;
   logic                    load;
   logic                    abort;
   logic [1:0]              digit_count;
   logic                    entry_err;
   logic [1:0]              state;

   modport master (
      output key_valid, key_code, busy,
      input  preset, load, abort, digit_count, entry_err, state
   );

   modport slave (
      input  key_valid, key_code, busy,
      output preset, load, abort, digit_count, entry_err, state
   );
endinterface

// File: rtl/timer_preset_entry_key_edge_detect.sv
// Rising-edge detector for a keypad level; history resets high so a key held
// through reset release never produces a press.
module timer_preset_entry_key_edge_detect (
   input  logic clk,
   input  logic clear,
   input  logic level,
   output logic press
);
   logic level_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         level_q <= 1'b1;
      end else begin
         level_q <= level;
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/timer_preset_entry.sv
// Converts keypad presses into a BCD M:SS preset, loads it into the down-counter
// chain and follows the chain's busy flag until the countdown ends or is cancelled.
module timer_preset_entry
   import timer_preset_entry_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 3,
   parameter logic [3:0]  KEY_START  = KEY_START_DEFAULT,
   parameter logic [3:0]  KEY_CANCEL = KEY_CANCEL_DEFAULT
) (
   input logic                 clk,
   input logic                 clear,
   timer_preset_entry_if.slave bus
);
   localparam int unsigned PresetW  = 4 * NUM_DIGITS;
   localparam logic [1:0]  MaxCount = 2'(NUM_DIGITS);

   state_e               state_q, state_d;
   logic [PresetW-1:0]   preset_q, preset_d;
   logic [1:0]           count_q, count_d;
   logic                 load_q, load_d;
   logic                 abort_q, abort_d;
   logic                 err_q, err_d;
   logic                 press;
   logic                 is_start, is_cancel, is_digit;
   logic                 tens_overflow;
   logic [PresetW-1:0]   preset_shifted;

   timer_preset_entry_key_edge_detect u_key_edge (
      .clk   (clk),
      .clear (clear),
      .level (bus.key_valid),
      .press (press)
   );

   assign is_start       = press && (bus.key_code == KEY_START);
   assign is_cancel      = press && (bus.key_code == KEY_CANCEL);
   assign is_digit       = press && is_digit_key(bus.key_code);
   // Current seconds-ones digit would become seconds-tens after the shift.
   assign tens_overflow  = (count_q != 2'd0) && (preset_q[3:0] > BCD_MAX_TENS_SEC);
   assign preset_shifted = {preset_q[PresetW-5:0], bus.key_code};

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      count_d  = count_q;
      load_d   = 1'b0;
      abort_d  = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         StEmpty: begin
            if (is_digit && (bus.key_code != 4'd0)) begin
               preset_d = preset_shifted;
               count_d  = count_q + 2'd1;
               state_d  = StEntry;
            end else if (is_start) begin
               err_d = 1'b1;
            end
         end
         StEntry: begin
            if (is_cancel) begin
               preset_d = '0;
               count_d  = 2'd0;
               state_d  = StEmpty;
            end else if (is_digit) begin
               if ((count_q == MaxCount) || tens_overflow) begin
                  err_d = 1'b1;
               end else begin
                  preset_d = preset_shifted;
                  count_d  = count_q + 2'd1;
               end
            end else if (is_start) begin
               load_d  = 1'b1;
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (is_cancel) begin
               preset_d = '0;
               count_d  = 2'd0;
               abort_d  = 1'b1;
               state_d  = StEmpty;
            end else if (bus.busy) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // Cancel takes priority over the countdown finishing in the same cycle.
            if (is_cancel || !bus.busy) begin
               preset_d = '0;
               count_d  = 2'd0;
               abort_d  = is_cancel;
               state_d  = StEmpty;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= StEmpty;
         preset_q <= '0;
         count_q  <= 2'd0;
         load_q   <= 1'b0;
         abort_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         load_q   <= load_d;
         abort_q  <= abort_d;
         err_q    <= err_d;
      end
   end

   assign bus.preset      = preset_q;
   assign bus.digit_count = count_q;
   assign bus.load        = load_q;
   assign bus.abort       = abort_q;
   assign bus.entry_err   = err_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_timer_preset_entry.sv
// Scoreboard bench: a digit-list reference model predicts each cycle's outputs,
// a separate monitor compares them one cycle after the stimulus edge.
module tb_timer_preset_entry;
   localparam int N = 3;

   typedef struct packed {
      logic [11:0] preset;
      logic [1:0]  count;
      logic [1:0]  state;
      logic        load;
      logic        abort;
      logic        err;
   } exp_t;

   logic clk;
   logic clear;
   timer_preset_entry_if #(.NUM_DIGITS(N)) bus ();

   timer_preset_entry #(
      .NUM_DIGITS (N),
      .KEY_START  (4'hA),
      .KEY_CANCEL (4'hB)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: digits entered, most significant first; phase 0..3.
   int   m_digits[$];
   int   m_phase = 0;
   bit   m_prev  = 1'b1;
   bit   busy_lvl = 1'b0;

   task automatic model_step(input bit clr, input bit kv, input logic [3:0] code,
                             input bit bsy);
      exp_t e;
      bit   press;
      int   v;
      e = '0;
      if (clr) begin
         m_digits.delete();
         m_phase = 0;
         m_prev  = 1'b1;
      end else begin
         press  = kv && !m_prev;
         m_prev = kv;
         if (press && code == 4'hB) begin
            if (m_phase >= 2) e.abort = 1'b1;
            m_digits.delete();
            m_phase = 0;
         end else if (m_phase == 3 && !bsy) begin
            m_digits.delete();
            m_phase = 0;
         end else if (m_phase == 2 && bsy) begin
            m_phase = 3;
         end else if (press && m_phase <= 1) begin
            if (code <= 4'd9) begin
               if (m_digits.size() == 0 && code == 4'd0) begin
                  // leading zero: nothing happens
               end else if (m_digits.size() == N) begin
                  e.err = 1'b1;
               end else if (m_digits.size() >= 1 && m_digits[$] > 5) begin
                  e.err = 1'b1;
               end else begin
                  m_digits.push_back(int'(code));
                  m_phase = 1;
               end
            end else if (code == 4'hA) begin
               if (m_phase == 1) begin
                  e.load  = 1'b1;
                  m_phase = 2;
               end else begin
                  e.err = 1'b1;
               end
            end
         end
      end
      v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      e.preset = 12'(v);
      e.count  = 2'(m_digits.size());
      e.state  = 2'(m_phase);
      sb.push_back(e);
   endtask

   task automatic step(input bit clr, input bit kv, input logic [3:0] code);
      @(negedge clk);
      clear         = clr;
      bus.key_valid = kv;
      bus.key_code  = code;
      bus.busy      = busy_lvl;
      model_step(clr, kv, code, busy_lvl);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 4'h0);
   endtask

   task automatic press_key(input logic [3:0] code, input int hold);
      repeat (hold) step(1'b0, 1'b1, code);
      idle(2);
   endtask

   task automatic do_reset();
      busy_lvl = 1'b0;
      repeat (2) step(1'b1, 1'b0, 4'h0);
   endtask

   // Monitor: outputs are registered, so every cycle presents a result.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a = '{preset: bus.preset, count: bus.digit_count, state: bus.state,
                  load: bus.load, abort: bus.abort, err: bus.entry_err};
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs @%0t: got preset=%h cnt=%0d st=%0d ld=%b ab=%b er=%b, want preset=%h cnt=%0d st=%0d ld=%b ab=%b er=%b",
                        $time, a.preset, a.count, a.state, a.load, a.abort, a.err,
                        e.preset, e.count, e.state, e.load, e.abort, e.err);
            end
         end
      end
   end

   initial begin
      logic [3:0] code;
      bit         kv;
      int         r;
      clear = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.busy      = 1'b0;

      // 1,3,0 then START, run, cancel in RUN
      do_reset();
      press_key(4'd1, 5); press_key(4'd3, 5); press_key(4'd0, 5);
      press_key(4'hA, 5);
      busy_lvl = 1'b1; idle(3);
      press_key(4'hB, 3);
      busy_lvl = 1'b0; idle(2);

      // leading zeros
      do_reset();
      press_key(4'd0, 2); press_key(4'd0, 2); press_key(4'd4, 2);

      // tens-of-seconds overflow
      do_reset();
      press_key(4'd7, 2); press_key(4'd2, 2);

      // too many digits, then START while empty
      do_reset();
      press_key(4'd1, 2); press_key(4'd2, 2); press_key(4'd3, 2); press_key(4'd4, 2);
      do_reset();
      press_key(4'hA, 2);

      // countdown finishes on its own
      do_reset();
      press_key(4'd9, 2); press_key(4'hA, 2);
      busy_lvl = 1'b1; idle(3);
      busy_lvl = 1'b0; idle(3);

      // cancel press and busy falling together
      press_key(4'd4, 2); press_key(4'hA, 2);
      busy_lvl = 1'b1; idle(2);
      busy_lvl = 1'b0; press_key(4'hB, 2);

      // key held across clear release
      repeat (3) step(1'b1, 1'b1, 4'd5);
      repeat (4) step(1'b0, 1'b1, 4'd5);
      idle(2);

      // clear while armed
      do_reset();
      press_key(4'd2, 2); press_key(4'hA, 2);
      step(1'b1, 1'b0, 4'h0);
      idle(3);

      // random traffic
      do_reset();
      kv   = 1'b0;
      code = 4'h0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            kv = ~kv;
            if (kv) begin
               r    = $urandom_range(0, 19);
               code = (r < 16) ? 4'(r) : ((r < 18) ? 4'hA : 4'hB);
            end
         end
         if ($urandom_range(0, 7) == 0) busy_lvl = ~busy_lvl;
         step(($urandom_range(0, 299) == 0), kv, code);
      end
      idle(2);

      @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
